oam_dma_master: RTL and testbench

- CPU-side sprite DMA initiator, modelled on the 2A03 $4014 engine; it is the bus master that drives the PPU register interface (RnW, RS, /DBE, D).
- A $4014 write halts the CPU, then the block copies 256 bytes from CPU page $XX00-$XXFF into PPU OAMDATA ($2004) by alternating read and write cycles.
- Sits between the CPU core, the CPU memory bus and the PPU register port in the console top.

---
 rtl/ppu_bus_pkg.sv | 25 ++
 rtl/oam_dma_getput.sv | 23 ++
 rtl/oam_dma_master.sv | 107 ++++++++++
 tb/tb_oam_dma_master.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ppu_bus_pkg.sv
// ppu_bus_pkg: shared definitions for masters of the PPU register port.
// Contents: DMA state encoding, PPU register-select constants and the
// CPU address of the sprite DMA trigger register.
package ppu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

    localparam logic [2:0] RS_PPUCTRL   = 3'd0;
    localparam logic [2:0] RS_PPUMASK   = 3'd1;
    localparam logic [2:0] RS_PPUSTATUS = 3'd2;
    localparam logic [2:0] RS_OAMADDR   = 3'd3;
    localparam logic [2:0] RS_OAMDATA   = 3'd4;
    localparam logic [2:0] RS_PPUSCROLL = 3'd5;
    localparam logic [2:0] RS_PPUADDR   = 3'd6;
    localparam logic [2:0] RS_PPUDATA   = 3'd7;

    localparam logic [15:0] OAMDMA_ADDR = 16'h4014;

endpackage

// File: rtl/oam_dma_getput.sv
// oam_dma_getput: CPU get/put cycle parity tracker, shareable between DMA engines.
// Ports:
//   CLK        - one CPU cycle per rising edge
//   RES        - synchronous active-high reset (current cycle becomes a get)
//   next_get_o - 1 when the next cycle is a get cycle
module oam_dma_getput (
    input  logic CLK,
    input  logic RES,
    output logic next_get_o
);

    // gp_q = 0 marks a get cycle, 1 a put cycle; it alternates unconditionally.
    logic gp_q;

    always_ff @(posedge CLK) begin
        if (RES) gp_q <= 1'b0;
        else     gp_q <= ~gp_q;
    end

    // Parity alternates, so the next cycle is a get exactly when this one is a put.
    assign next_get_o = gp_q;

endmodule

// File: rtl/oam_dma_master.sv
// oam_dma_master: $4014 sprite DMA engine copying a 256-byte CPU page into PPU OAMDATA.
// Ports:
//   CLK, RES          - CPU cycle clock, synchronous active-high reset
//   W4014, PAGE_in    - trigger strobe and source page
//   CPU_RnW           - CPU read/write of the current cycle (halt only lands on a read)
//   RDY               - CPU ready (0 = halted)
//   DMA_OWN           - engine owns the CPU bus
//   ADDR, RnW, D_in, D_out - CPU bus master signals
//   RS, n_DBE         - PPU register select and active-low data bus enable
// Optional feature macro: SPRDMA_RESTART_EN (a trigger during a copy restarts it).
module oam_dma_master
    import ppu_bus_pkg::*;
#(
    parameter logic [2:0]  DST_RS   = RS_OAMDATA,
    parameter logic [15:0] DST_ADDR = 16'h2004
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        W4014,
    input  logic [7:0]  PAGE_in,
    input  logic        CPU_RnW,
    output logic        RDY,
    output logic        DMA_OWN,
    output logic [15:0] ADDR,
    output logic        RnW,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic [2:0]  RS,
    output logic        n_DBE
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       next_get;
    logic       rd, wr;

    oam_dma_getput u_getput (
        .CLK        (CLK),
        .RES        (RES),
        .next_get_o (next_get)
    );

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (W4014) begin
                    page_d  = PAGE_in;
                    state_d = ST_HALT;
                end
            end
            // The CPU only stops on a read cycle; reads must land on get cycles,
            // so a halt that falls on a get burns one ALIGN cycle first.
            ST_HALT: begin
                if (CPU_RnW) state_d = next_get ? ST_READ : ST_ALIGN;
            end
            ST_ALIGN: state_d = ST_READ;
            ST_READ: begin
                data_d  = D_in;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = (cnt_q == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SPRDMA_RESTART_EN
        // A write already on the bus finishes this cycle; only the follow-up changes.
        if (W4014 && (state_q == ST_READ || state_q == ST_WRITE)) begin
            page_d  = PAGE_in;
            cnt_d   = 8'h00;
            state_d = ST_HALT;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= ST_IDLE;
            page_q  <= 8'h00;
            cnt_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign rd      = (state_q == ST_READ);
    assign wr      = (state_q == ST_WRITE);
    assign RDY     = (state_q == ST_IDLE);
    assign DMA_OWN = state_q inside {ST_ALIGN, ST_READ, ST_WRITE};
    assign ADDR    = wr ? DST_ADDR : rd ? {page_q, cnt_q} : 16'h0000;
    assign RnW     = ~wr;
    assign D_out   = wr ? data_q : 8'h00;
    assign RS      = wr ? DST_RS : 3'd0;
    assign n_DBE   = ~wr;

endmodule

// File: tb/tb_oam_dma_master.sv
// tb_oam_dma_master: table-driven self-checking bench for oam_dma_master.
module tb_oam_dma_master;

`ifdef SPRDMA_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        W4014 = 1'b0;
    logic [7:0]  PAGE_in = 8'h00;
    logic        CPU_RnW = 1'b1;
    logic        RDY, DMA_OWN, RnW, n_DBE;
    logic [15:0] ADDR;
    logic [7:0]  D_in, D_out;
    logic [2:0]  RS;

    logic [7:0] ram [0:65535];
    assign D_in = ram[ADDR];

    always #5 CLK = ~CLK;

    oam_dma_master dut (
        .CLK(CLK), .RES(RES), .W4014(W4014), .PAGE_in(PAGE_in), .CPU_RnW(CPU_RnW),
        .RDY(RDY), .DMA_OWN(DMA_OWN), .ADDR(ADDR), .RnW(RnW), .D_in(D_in),
        .D_out(D_out), .RS(RS), .n_DBE(n_DBE)
    );

    // Reference get/put parity: 0 = get, toggles every cycle, cleared by reset.
    logic gp_m;
    always @(posedge CLK) gp_m <= RES ? 1'b0 : ~gp_m;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [7:0] page;
        bit         halt_get;
        int         holdoff;
        int         rst_at;
        int         w_at;
        logic [7:0] w_page;
    } vec_t;

    vec_t vecs[7];

    int          halt_len, own0, wr_bad;
    bit          timeout;
    logic [3:0]  end_flags;
    logic [7:0]  wr_q[$];
    logic [15:0] rd_q[$];

    function automatic logic [7:0] src_byte(input logic [7:0] p, input logic [7:0] i);
        return i ^ p ^ 8'h58;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start a transfer so that the halt-on-read cycle lands on get or put,
    // then watch the bus until RDY returns, injecting RES/W4014 on a chosen write.
    task automatic run(input vec_t v);
        int k;
        bit g;
        bit done;
        wr_q.delete();
        rd_q.delete();
        halt_len = 0;
        own0 = 0;
        wr_bad = 0;
        timeout = 0;
        end_flags = 4'h0;
        g = v.halt_get ^ (v.holdoff % 2 == 1);
        do begin
            @(posedge CLK); #1;
        end while (gp_m !== g);
        W4014 = 1'b1;
        PAGE_in = v.page;
        CPU_RnW = 1'b0;
        @(posedge CLK); #1;
        W4014 = 1'b0;
        k = 0;
        done = 0;
        while (!done) begin
            CPU_RnW = (k >= v.holdoff);
            @(negedge CLK);
            if (RDY === 1'b1) begin
                done = 1;
                end_flags = {RDY, DMA_OWN, n_DBE, RnW};
            end else begin
                halt_len++;
                if (!DMA_OWN) own0++;
                if (DMA_OWN && RnW) rd_q.push_back(ADDR);
                if (!n_DBE) begin
                    if (RS !== 3'd4 || ADDR !== 16'h2004 || RnW !== 1'b0) wr_bad++;
                    if (wr_q.size() == v.rst_at) RES = 1'b1;
                    if (wr_q.size() == v.w_at) begin
                        W4014 = 1'b1;
                        PAGE_in = v.w_page;
                    end
                    wr_q.push_back(D_out);
                end
                k++;
                if (k > 2000) begin
                    done = 1;
                    timeout = 1;
                end
                @(posedge CLK); #1;
                RES = 1'b0;
                W4014 = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0]  ew[$];
        logic [15:0] er[$];
        logic [15:0] aa;
        int n1, dm, idle_bad;
        bit plain, restarted;
        for (int a = 0; a < 65536; a++) begin
            aa = a;
            ram[a] = src_byte(aa[15:8], aa[7:0]);
        end
        vecs[0] = '{"basic",    8'h02, 1'b1, 0, -1,  -1,    8'h00};
        vecs[1] = '{"align",    8'h02, 1'b0, 0, -1,  -1,    8'h00};
        vecs[2] = '{"holdoff",  8'h02, 1'b0, 3, -1,  -1,    8'h00};
        vecs[3] = '{"rst80",    8'h02, 1'b1, 0, 128, -1,    8'h00};
        vecs[4] = '{"after_rst",8'h02, 1'b1, 0, -1,  -1,    8'h00};
        vecs[5] = '{"retrig",   8'h02, 1'b0, 0, -1,  16,    8'h03};
        vecs[6] = '{"wrap",     8'hFF, 1'b0, 0, -1,  -1,    8'h00};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst.rdy",   RDY, 1);
        check("rst.own",   DMA_OWN, 0);
        check("rst.rnw",   RnW, 1);
        check("rst.ndbe",  n_DBE, 1);
        check("rst.rs",    RS, 0);
        check("rst.addr",  ADDR, 0);
        check("rst.dout",  D_out, 0);
        @(posedge CLK); #1;
        RES = 1'b0;

        foreach (vecs[n]) begin
            run(vecs[n]);
            restarted = RESTART && vecs[n].w_at >= 0;
            plain = vecs[n].rst_at < 0 && !restarted;
            ew.delete();
            n1 = vecs[n].rst_at >= 0 ? vecs[n].rst_at + 1 : restarted ? vecs[n].w_at + 1 : 256;
            for (int i = 0; i < n1; i++) ew.push_back(src_byte(vecs[n].page, 8'(i)));
            if (restarted)
                for (int i = 0; i < 256; i++) ew.push_back(src_byte(vecs[n].w_page, 8'(i)));
            check({vecs[n].name, ".timeout"}, timeout, 0);
            check({vecs[n].name, ".end_flags"}, end_flags, 4'b1011);
            check({vecs[n].name, ".wr_bus"}, wr_bad, 0);
            check({vecs[n].name, ".wr_count"}, wr_q.size(), ew.size());
            dm = 0;
            for (int i = 0; i < wr_q.size() && i < ew.size(); i++) if (wr_q[i] !== ew[i]) dm++;
            check({vecs[n].name, ".wr_data_errs"}, dm, 0);
            if (plain) begin
                check({vecs[n].name, ".halt_len"}, halt_len, vecs[n].holdoff + (vecs[n].halt_get ? 514 : 513));
                check({vecs[n].name, ".halt_unowned"}, own0, vecs[n].holdoff + 1);
                er.delete();
                if (vecs[n].halt_get) er.push_back(16'h0000);
                for (int i = 0; i < 256; i++) er.push_back({vecs[n].page, 8'(i)});
                check({vecs[n].name, ".rd_count"}, rd_q.size(), er.size());
                dm = 0;
                for (int i = 0; i < rd_q.size() && i < er.size(); i++) if (rd_q[i] !== er[i]) dm++;
                check({vecs[n].name, ".rd_addr_errs"}, dm, 0);
                if (rd_q.size() > 0) check({vecs[n].name, ".last_rd"}, rd_q[rd_q.size()-1], {vecs[n].page, 8'hFF});
            end
            idle_bad = 0;
            repeat (8) begin
                @(negedge CLK);
                if (n_DBE !== 1'b1 || RDY !== 1'b1 || DMA_OWN !== 1'b0) idle_bad++;
            end
            check({vecs[n].name, ".idle_after"}, idle_bad, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
